freq_result_reader: RTL and testbench

- Control and read-out end of the frequency buffer. On a host start request it programs the sample count, raises enable, and waits for the buffer's done_flag.
- done_flag arrives in the in_wave domain and is synchronised into Clock.
- On completion the block snapshots the 8-entry history and the average, then streams them as tagged 16-bit words over a valid/ready interface to the host/UART packetiser.

---
 rtl/freq_pkg.sv | 9 +
 rtl/sync_edge.sv | 22 ++
 rtl/freq_result_reader.sv | 105 ++++++++++
 tb/tb_freq_result_reader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// freq_pkg: shared widths, word tags and reader states for the frequency buffer read-out
package freq_pkg;
    localparam int FREQ_W = 10;
    localparam int NUM_SAMPLES = 8;
    localparam logic [3:0] TAG_HDR = 4'hF;
    localparam logic [3:0] TAG_AVG = 4'h9;
    localparam logic [3:0] TAG_ERR = 4'hE;
    typedef enum logic [2:0] {IDLE, WAIT_DONE, CAPTURE, SEND, ERR} state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchroniser for a slow foreign-domain flag, with a one-cycle rising-edge pulse
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic nReset,
    input  logic d,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic last_q;
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end
    assign rise = sync_q[SYNC_STAGES-1] & ~last_q;
endmodule

// File: rtl/freq_result_reader.sv
// freq_result_reader: starts a buffer run, waits for done (with timeout), snapshots the
// history and average, and streams them as tagged 16-bit words over valid/ready
module freq_result_reader
    import freq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              start,
    input  logic [15:0]       samples_req_in,
    output logic              enable,
    output logic [15:0]       samples_required,
    input  logic              done_flag,
    input  logic [FREQ_W-1:0] average_in,
    input  logic [FREQ_W-1:0] buff_in [NUM_SAMPLES-1:0],
    output logic [15:0]       dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              result_done,
    output logic              timeout_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
    state_t state, state_nxt;
    logic done_rise, accept, run_start, last_word, timed_out;
    logic [CW-1:0] cnt;
    logic [3:0] idx;
    logic [2:0] sel;
    logic [FREQ_W-1:0] snap [NUM_SAMPLES-1:0];
    logic [FREQ_W-1:0] avg;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .Clock (Clock),
        .nReset(nReset),
        .d     (done_flag),
        .rise  (done_rise)
    );

    assign accept     = dout_valid & dout_ready;
    assign run_start  = start && samples_req_in != '0;
    assign last_word  = idx == 4'd9;
    assign timed_out  = cnt == CNT_MAX;
    assign sel        = 3'(idx - 4'd1);
    assign enable     = state == WAIT_DONE;
    assign busy       = state != IDLE;
    assign dout_valid = state == SEND || state == ERR;

    always_comb begin
        dout = '0;
        if (state == ERR)
            dout = {TAG_ERR, 12'h000};
        else if (state == SEND)
            dout = idx == 4'd0 ? {TAG_HDR, samples_required[11:0]} :
                   last_word   ? {TAG_AVG, 2'b00, avg} :
                                 {idx, 2'b00, snap[sel]};
    end

    // done_rise is tested before the timeout so a coincident completion still captures
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = run_start ? WAIT_DONE : IDLE;
            WAIT_DONE: state_nxt = done_rise ? CAPTURE : timed_out ? ERR : WAIT_DONE;
            CAPTURE:   state_nxt = SEND;
            SEND:      state_nxt = accept && last_word ? IDLE : SEND;
            ERR:       state_nxt = accept ? IDLE : ERR;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state            <= IDLE;
            samples_required <= '0;
            cnt              <= '0;
            idx              <= '0;
            avg              <= '0;
            snap             <= '{default: '0};
            timeout_err      <= 1'b0;
            result_done      <= 1'b0;
        end else begin
            state       <= state_nxt;
            result_done <= state == SEND && accept && last_word;
            if (state == IDLE && run_start) begin
                samples_required <= samples_req_in;
                cnt              <= '0;
                timeout_err      <= 1'b0;
            end
            if (state == WAIT_DONE && !timed_out)
                cnt <= cnt + CW'(1);
            if (state == WAIT_DONE && !done_rise && timed_out)
                timeout_err <= 1'b1;
            if (state == CAPTURE) begin
                snap <= buff_in;
                avg  <= average_in;
                idx  <= '0;
            end
            if (state == SEND && accept)
                idx <= idx + 4'd1;
        end
    end
endmodule

// File: tb/tb_freq_result_reader.sv
// tb_freq_result_reader: scoreboard bench; expected words are queued when done_flag is driven
module tb_freq_result_reader;
    import freq_pkg::*;
    logic Clock = 0, nReset = 0, start = 0, done_flag = 0, dout_ready = 1;
    logic [15:0] samples_req_in = 0;
    logic [FREQ_W-1:0] average_in = 0;
    logic [FREQ_W-1:0] buff_in [NUM_SAMPLES-1:0];
    logic enable, dout_valid, busy, result_done, timeout_err;
    logic [15:0] samples_required, dout;
    int n_chk = 0, n_pass = 0, acc_cnt = 0, phase = 0;
    logic [16:0] exp_q [$];
    logic [16:0] mon_e;
    logic bp = 0, done_due = 0, held = 0;
    logic [15:0] held_dout = 0;
    logic [3:0] pat = 4'b1001;

    always #5 Clock = ~Clock;

    freq_result_reader #(.TIMEOUT_CYCLES(100), .SYNC_STAGES(2)) dut (
        .Clock           (Clock),
        .nReset          (nReset),
        .start           (start),
        .samples_req_in  (samples_req_in),
        .enable          (enable),
        .samples_required(samples_required),
        .done_flag       (done_flag),
        .average_in      (average_in),
        .buff_in         (buff_in),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .busy            (busy),
        .result_done     (result_done),
        .timeout_err     (timeout_err)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    initial forever begin
        @(posedge Clock);
        #1;
        dout_ready = bp ? pat[phase % 4] : 1'b1;
        phase++;
    end

    always @(negedge Clock) if (nReset) begin
        if (done_due || result_done) check("result_done", 16'(result_done), 16'(done_due));
        done_due = 0;
        if (held && dout_valid) check("hold", dout, held_dout);
        held = dout_valid && !dout_ready;
        held_dout = dout;
        if (dout_valid && dout_ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) check("unexpected_word", dout, 16'h0000);
            else begin
                mon_e = exp_q.pop_front();
                check("word", dout, mon_e[15:0]);
                done_due = mon_e[16];
            end
        end
    end

    task automatic set_buf(input bit rnd);
        for (int i = 0; i < NUM_SAMPLES; i++)
            buff_in[i] = rnd ? FREQ_W'($urandom_range(0, 1023)) : FREQ_W'(100 + i);
        average_in = rnd ? FREQ_W'($urandom_range(0, 1023)) : FREQ_W'(103);
    endtask

    task automatic push_pkt(input logic [15:0] s);
        exp_q.push_back({1'b0, 4'hF, s[11:0]});
        for (int i = 1; i <= 8; i++) exp_q.push_back({1'b0, 4'(i), 2'b00, buff_in[i-1]});
        exp_q.push_back({1'b1, 4'h9, 2'b00, average_in});
    endtask

    task automatic start_run(input logic [15:0] s);
        start = 1;
        samples_req_in = s;
        tick;
        start = 0;
    endtask

    task automatic drain;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick;
        tick;
        tick;
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        check("idle_after", 16'(busy), 16'd0);
    endtask

    task automatic run_done(input logic [15:0] s, input int pre);
        repeat (pre) tick;
        done_flag = 1;
        push_pkt(s);
        tick;
        tick;
        check("enable_before_rise", 16'(enable), 16'd1);
        tick;
        check("enable_dropped", 16'(enable), 16'd0);
        check("no_timeout", 16'(timeout_err), 16'd0);
        drain;
        done_flag = 0;
        repeat (3) tick;
    endtask

    initial begin
        int base;
        for (int i = 0; i < NUM_SAMPLES; i++) buff_in[i] = '0;
        #2;
        check("rst_dout", dout, 16'h0000);
        check("rst_valid", 16'(dout_valid), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_enable", 16'(enable), 16'd0);
        check("rst_result_done", 16'(result_done), 16'd0);
        check("rst_timeout_err", 16'(timeout_err), 16'd0);
        check("rst_samples", samples_required, 16'h0000);
        tick;
        tick;
        nReset = 1;
        tick;
        start_run(16'd0);
        check("zero_start_busy", 16'(busy), 16'd0);
        check("zero_start_samples", samples_required, 16'h0000);
        set_buf(0);
        start_run(16'd20);
        check("run_busy", 16'(busy), 16'd1);
        check("run_enable", 16'(enable), 16'd1);
        check("run_samples", samples_required, 16'd20);
        start_run(16'd5);
        check("busy_start_ignored", samples_required, 16'd20);
        run_done(16'd20, 1);
        bp = 1;
        set_buf(1);
        start_run(16'h1234);
        run_done(16'h1234, 3);
        bp = 0;
        start_run(16'd7);
        repeat (99) tick;
        check("to_enable_held", 16'(enable), 16'd1);
        check("to_err_clear", 16'(timeout_err), 16'd0);
        exp_q.push_back({1'b0, 16'hE000});
        tick;
        check("to_enable_drop", 16'(enable), 16'd0);
        check("to_err_set", 16'(timeout_err), 16'd1);
        drain;
        check("to_err_sticky", 16'(timeout_err), 16'd1);
        set_buf(1);
        start_run(16'd3);
        check("to_err_cleared", 16'(timeout_err), 16'd0);
        run_done(16'd3, 3);
        set_buf(1);
        start_run(16'd9);
        run_done(16'd9, 97);
        check("coincident_no_err", 16'(timeout_err), 16'd0);
        set_buf(1);
        start_run(16'd42);
        base = acc_cnt;
        repeat (3) tick;
        done_flag = 1;
        push_pkt(16'd42);
        for (int i = 0; i < 100 && acc_cnt < base + 5; i++) tick;
        check("reached_word4", 16'(acc_cnt - base >= 5), 16'd1);
        #2;
        nReset = 0;
        #1;
        check("rst_mid_valid", 16'(dout_valid), 16'd0);
        check("rst_mid_busy", 16'(busy), 16'd0);
        check("rst_mid_enable", 16'(enable), 16'd0);
        check("rst_mid_dout", dout, 16'h0000);
        exp_q.delete();
        held = 0;
        done_due = 0;
        done_flag = 0;
        tick;
        tick;
        nReset = 1;
        tick;
        check("post_rst_idle", 16'(busy), 16'd0);
        set_buf(1);
        start_run(16'd77);
        run_done(16'd77, 3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
